// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one line-wide main-memory port between the I-cache and D-cache.
// One cache is granted per transaction. Its request is registered and held on memory
// until in_mem_ready. The line then returns with a one-cycle ready pulse to that cache.
//
// Optional build macro: MEM_ARB_ROUND_ROBIN_EN
//   defined   : simultaneous I/D requests alternate, using a last_grant register
//   undefined : fixed priority, the D-cache wins every tie
//
// state  | meaning
// IDLE   | sample requests, grant one cache, latch its transaction
// MEM_I  | I-cache transaction held on memory until in_mem_ready
// MEM_D  | D-cache transaction held on memory until in_mem_ready
// RESP   | one-cycle ready pulse and line to the owner
module mem_arbiter #(
  parameter int CACHE_LINE_SIZE = 128,
  parameter int ADDR_WIDTH      = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_icache_read_en,
  input  logic [ADDR_WIDTH-1:0]      in_icache_addr,
  output logic [CACHE_LINE_SIZE-1:0] out_icache_read_data,
  output logic                       out_icache_ready,
  input  logic                       in_dcache_read_en,
  input  logic                       in_dcache_write_en,
  input  logic [ADDR_WIDTH-1:0]      in_dcache_addr,
  input  logic [CACHE_LINE_SIZE-1:0] in_dcache_write_data,
  output logic [CACHE_LINE_SIZE-1:0] out_dcache_read_data,
  output logic                       out_dcache_ready,
  output logic                       out_mem_read_en,
  output logic                       out_mem_write_en,
  output logic [ADDR_WIDTH-1:0]      out_mem_addr,
  output logic [CACHE_LINE_SIZE-1:0] out_mem_write_data,
  input  logic [CACHE_LINE_SIZE-1:0] in_mem_read_data,
  input  logic                       in_mem_ready
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MEM_I = 2'd1,
    S_MEM_D = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                     r_state;
  state_t                     w_next;
  logic [ADDR_WIDTH-1:0]      r_addr;
  logic [CACHE_LINE_SIZE-1:0] r_wdata;
  logic [CACHE_LINE_SIZE-1:0] r_rdata;
  logic                       r_is_write;
  logic                       r_owner_d;
  logic                       w_req_i;
  logic                       w_req_d;
  logic                       w_grant_i;
  logic                       w_grant_d;
  logic                       w_in_mem;

  assign w_req_i  = in_icache_read_en;
  assign w_req_d  = in_dcache_read_en | in_dcache_write_en;
  assign w_in_mem = (r_state == S_MEM_I) || (r_state == S_MEM_D);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic r_last_d;

  // On a tie, D is granted only if I was the last cache served.
  assign w_grant_d = w_req_d & (~w_req_i | ~r_last_d);

  // Remember the most recently served cache; it is updated once the transaction completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_d <= 1'b1;
    end else if (r_state == S_RESP) begin
      r_last_d <= r_owner_d;
    end
  end
`else
  // Fixed priority: any D request beats an I request.
  assign w_grant_d = w_req_d;
`endif

  assign w_grant_i = w_req_i & ~w_grant_d;

  // The memory side is driven only from registers, so cache inputs are ignored mid-transaction.
  assign out_mem_addr       = r_addr;
  assign out_mem_write_data = r_wdata;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic and decoded outputs.
  always_comb begin
    w_next               = r_state;
    out_mem_read_en      = 1'b0;
    out_mem_write_en     = 1'b0;
    out_icache_ready     = 1'b0;
    out_dcache_ready     = 1'b0;
    out_icache_read_data = '0;
    out_dcache_read_data = '0;
    case (r_state)
      S_IDLE: begin
        if (w_grant_d) begin
          w_next = S_MEM_D;
        end else if (w_grant_i) begin
          w_next = S_MEM_I;
        end
      end
      S_MEM_I, S_MEM_D: begin
        out_mem_read_en  = ~r_is_write;
        out_mem_write_en = r_is_write;
        if (in_mem_ready) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        if (r_owner_d) begin
          out_dcache_ready     = 1'b1;
          out_dcache_read_data = r_is_write ? '0 : r_rdata;
        end else begin
          out_icache_ready     = 1'b1;
          out_icache_read_data = r_rdata;
        end
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Latch the granted transaction in IDLE, and capture the returned line in MEM.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_is_write <= 1'b0;
      r_owner_d  <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (w_grant_d) begin
        r_addr     <= in_dcache_addr;
        r_wdata    <= in_dcache_write_data;
        r_is_write <= in_dcache_write_en;
        r_owner_d  <= 1'b1;
      end else if (w_grant_i) begin
        r_addr     <= in_icache_addr;
        r_wdata    <= '0;
        r_is_write <= 1'b0;
        r_owner_d  <= 1'b0;
      end
    end else if (w_in_mem && in_mem_ready) begin
      r_rdata <= in_mem_read_data;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter. A memory responder model answers transactions with random
// latency and data, and pushes each expected cache response into a per-cache queue.
// A monitor pops those queues on every ready pulse.
// The arbitration order comes from a grant-order model kept in the bench.
module tb_mem_arbiter;
  localparam int LW = 128;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_icache_read_en;
  logic [AW-1:0] in_icache_addr;
  logic [LW-1:0] out_icache_read_data;
  logic          out_icache_ready;
  logic          in_dcache_read_en;
  logic          in_dcache_write_en;
  logic [AW-1:0] in_dcache_addr;
  logic [LW-1:0] in_dcache_write_data;
  logic [LW-1:0] out_dcache_read_data;
  logic          out_dcache_ready;
  logic          out_mem_read_en;
  logic          out_mem_write_en;
  logic [AW-1:0] out_mem_addr;
  logic [LW-1:0] out_mem_write_data;
  logic [LW-1:0] in_mem_read_data;
  logic          in_mem_ready;

  mem_arbiter #(.CACHE_LINE_SIZE(LW), .ADDR_WIDTH(AW)) dut (
    .clk                  (clk),
    .reset                (reset),
    .in_icache_read_en    (in_icache_read_en),
    .in_icache_addr       (in_icache_addr),
    .out_icache_read_data (out_icache_read_data),
    .out_icache_ready     (out_icache_ready),
    .in_dcache_read_en    (in_dcache_read_en),
    .in_dcache_write_en   (in_dcache_write_en),
    .in_dcache_addr       (in_dcache_addr),
    .in_dcache_write_data (in_dcache_write_data),
    .out_dcache_read_data (out_dcache_read_data),
    .out_dcache_ready     (out_dcache_ready),
    .out_mem_read_en      (out_mem_read_en),
    .out_mem_write_en     (out_mem_write_en),
    .out_mem_addr         (out_mem_addr),
    .out_mem_write_data   (out_mem_write_data),
    .in_mem_read_data     (in_mem_read_data),
    .in_mem_ready         (in_mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          is_write;
    logic          owner_d;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
  } txn_t;

  txn_t          mem_q[$];
  logic [LW-1:0] exp_i[$];
  logic [LW-1:0] exp_d[$];

  int n_total   = 0;
  int n_pass    = 0;
  int zero_viol = 0;

  int            cfg_lat     = 0;
  bit            cfg_data_en = 1'b0;
  logic [LW-1:0] cfg_data    = '0;
  bit            spurious_en = 1'b0;
  int            last_lat    = 0;
  bit            last_d      = 1'b1;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [LW-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Memory responder model: answers each transaction after its chosen latency,
  // and sometimes sends stray ready pulses while no strobe is active.
  initial begin : responder
    bit            pending;
    int            cnt;
    int            lat;
    bit            strobe;
    txn_t          cur;
    logic [LW-1:0] d;
    pending          = 1'b0;
    cnt              = 0;
    in_mem_ready     = 1'b0;
    in_mem_read_data = '0;
    forever begin
      @(negedge clk);
      in_mem_ready     = 1'b0;
      in_mem_read_data = '0;
      if (reset) begin
        pending = 1'b0;
        continue;
      end
      strobe = out_mem_read_en | out_mem_write_en;
      if (strobe && !pending) begin
        pending  = 1'b1;
        lat      = (cfg_lat != 0) ? cfg_lat : int'($urandom_range(1, 4));
        last_lat = lat;
        cnt      = lat - 1;
        if (mem_q.size() == 0) begin
          chk("mem_unexpected_txn", LW'(1), LW'(0));
          cur.is_write = out_mem_write_en;
          cur.owner_d  = 1'b0;
          cur.addr     = out_mem_addr;
          cur.wdata    = out_mem_write_data;
        end else begin
          cur = mem_q.pop_front();
        end
        chk("mem_write_en", LW'(out_mem_write_en), LW'(cur.is_write));
        chk("mem_read_en", LW'(out_mem_read_en), LW'(!cur.is_write));
        chk("mem_addr", LW'(out_mem_addr), LW'(cur.addr));
        if (cur.is_write) chk("mem_write_data", out_mem_write_data, cur.wdata);
      end else if (pending) begin
        cnt--;
        chk("mem_strobe_held", LW'(strobe), LW'(1));
        chk("mem_addr_held", LW'(out_mem_addr), LW'(cur.addr));
      end
      if (pending && cnt == 0) begin
        d                = cfg_data_en ? cfg_data : rand_line();
        in_mem_ready     = 1'b1;
        in_mem_read_data = d;
        if (cur.owner_d) exp_d.push_back(cur.is_write ? '0 : d);
        else             exp_i.push_back(d);
        pending = 1'b0;
      end else if (!strobe && !pending && spurious_en && $urandom_range(0, 3) == 0) begin
        in_mem_ready     = 1'b1;
        in_mem_read_data = rand_line();
      end
    end
  end

  // Monitor: each ready pulse must match the next expected line for that cache.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (out_icache_ready) begin
          if (exp_i.size() == 0) chk("icache_unexpected_ready", LW'(1), LW'(0));
          else chk("icache_read_data", out_icache_read_data, exp_i.pop_front());
        end else if (out_icache_read_data != '0) begin
          zero_viol++;
        end
        if (out_dcache_ready) begin
          if (exp_d.size() == 0) chk("dcache_unexpected_ready", LW'(1), LW'(0));
          else chk("dcache_read_data", out_dcache_read_data, exp_d.pop_front());
        end else if (out_dcache_read_data != '0) begin
          zero_viol++;
        end
      end
    end
  end

  function automatic txn_t mk_txn(input bit is_d, input bit wr, input logic [AW-1:0] a,
                                  input logic [LW-1:0] wd);
    txn_t t;
    t.is_write = is_d & wr;
    t.owner_d  = is_d;
    t.addr     = a;
    t.wdata    = wd;
    return t;
  endfunction

  // One round: assert the chosen requests together, hold each until its ready pulse, then drop it.
  task automatic run_round(input bit ri, input bit rd, input bit dw, input bit rd_also,
                           input logic [AW-1:0] ai, input logic [AW-1:0] ad,
                           input logic [LW-1:0] wd, input bit perturb);
    bit first_d;
    bit done_i;
    bit done_d;
    int cyc;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    first_d = rd && (!ri || !last_d);
`else
    first_d = rd;
`endif
    if (first_d) begin
      mem_q.push_back(mk_txn(1'b1, dw, ad, wd));
      last_d = 1'b1;
      if (ri) begin
        mem_q.push_back(mk_txn(1'b0, 1'b0, ai, '0));
        last_d = 1'b0;
      end
    end else begin
      if (ri) begin
        mem_q.push_back(mk_txn(1'b0, 1'b0, ai, '0));
        last_d = 1'b0;
      end
      if (rd) begin
        mem_q.push_back(mk_txn(1'b1, dw, ad, wd));
        last_d = 1'b1;
      end
    end
    @(negedge clk);
    in_icache_read_en    = ri;
    in_icache_addr       = ai;
    in_dcache_read_en    = rd & (!dw | rd_also);
    in_dcache_write_en   = rd & dw;
    in_dcache_addr       = ad;
    in_dcache_write_data = wd;
    done_i = !ri;
    done_d = !rd;
    cyc    = 0;
    while (!(done_i && done_d) && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (perturb && cyc == 1) begin
        in_icache_addr       = ai ^ 32'h0000_00C0;
        in_dcache_addr       = ad ^ 32'h0000_00C0;
        in_dcache_write_data = ~wd;
      end
      if (out_icache_ready && !done_i) begin
        done_i            = 1'b1;
        in_icache_read_en = 1'b0;
        if (!rd) chk("icache_latency", LW'(cyc), LW'(last_lat + 1));
      end
      if (out_dcache_ready && !done_d) begin
        done_d             = 1'b1;
        in_dcache_read_en  = 1'b0;
        in_dcache_write_en = 1'b0;
        if (!ri) chk("dcache_latency", LW'(cyc), LW'(last_lat + 1));
      end
    end
    chk("round_done", LW'({done_i, done_d}), LW'(2'b11));
    in_icache_read_en  = 1'b0;
    in_dcache_read_en  = 1'b0;
    in_dcache_write_en = 1'b0;
  endtask

  initial begin : stim
    logic [AW-1:0] ai;
    logic [AW-1:0] ad;
    int            kind;
    reset                = 1'b1;
    in_icache_read_en    = 1'b0;
    in_icache_addr       = '0;
    in_dcache_read_en    = 1'b0;
    in_dcache_write_en   = 1'b0;
    in_dcache_addr       = '0;
    in_dcache_write_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_mem_read_en", LW'(out_mem_read_en), LW'(0));
    chk("rst_mem_write_en", LW'(out_mem_write_en), LW'(0));
    chk("rst_mem_addr", LW'(out_mem_addr), LW'(0));
    chk("rst_icache_ready", LW'(out_icache_ready), LW'(0));
    chk("rst_dcache_ready", LW'(out_dcache_ready), LW'(0));
    reset  = 1'b0;
    last_d = 1'b1;

    // I-cache fill, memory answers on its third strobe cycle.
    cfg_lat     = 3;
    cfg_data_en = 1'b1;
    cfg_data    = {4{32'hA5A5_A5A5}};
    run_round(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 32'h0, '0, 1'b0);
    cfg_data_en = 1'b0;
    cfg_lat     = 0;

    // D-cache writeback; the read data returned to the cache must be zero.
    run_round(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_2000,
              {32'h1234_5678, 32'h9ABC_DEF0, 32'h0F1E_2D3C, 32'h4B5A_6978}, 1'b0);

    // Simultaneous requests, twice, to see the tie-break order.
    run_round(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0500, 32'h0000_0600, '0, 1'b0);
    run_round(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0700, 32'h0000_0800, rand_line(), 1'b0);

    // D-cache changes its address 0x40 -> 0x80 while its transaction is in flight.
    cfg_lat = 4;
    run_round(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_0040, '0, 1'b1);

    // Reset during the second strobe cycle of an I fill: the fill is abandoned.
    cfg_lat = 6;
    mem_q.push_back(mk_txn(1'b0, 1'b0, 32'h0000_0300, '0));
    @(negedge clk);
    in_icache_read_en = 1'b1;
    in_icache_addr    = 32'h0000_0300;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_mem_read_en", LW'(out_mem_read_en), LW'(1));
    reset = 1'b1;
    @(negedge clk);
    in_icache_read_en = 1'b0;
    chk("midrst_mem_read_en", LW'(out_mem_read_en), LW'(0));
    chk("midrst_mem_write_en", LW'(out_mem_write_en), LW'(0));
    chk("midrst_icache_ready", LW'(out_icache_ready), LW'(0));
    @(negedge clk);
    reset   = 1'b0;
    last_d  = 1'b1;
    cfg_lat = 0;

    // Stray memory ready pulses while idle must have no effect.
    spurious_en = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("idle_strobes", LW'({out_mem_read_en, out_mem_write_en}), LW'(0));
      chk("idle_readies", LW'({out_icache_ready, out_dcache_ready}), LW'(0));
    end

    // Randomized traffic.
    for (int r = 0; r < 60; r++) begin
      kind = int'($urandom_range(0, 2));
      ai   = $urandom & 32'hFFFF_FFF0;
      ad   = $urandom & 32'hFFFF_FFF0;
      if (ad == ai) ad = ai ^ 32'h0000_0040;
      run_round(kind != 1, kind != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ai, ad, rand_line(), (kind != 2) && ($urandom_range(0, 1) == 1));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    spurious_en = 1'b0;

    repeat (4) @(negedge clk);
    chk("mem_queue_drained", LW'(mem_q.size()), LW'(0));
    chk("icache_queue_drained", LW'(exp_i.size()), LW'(0));
    chk("dcache_queue_drained", LW'(exp_d.size()), LW'(0));
    chk("read_data_zero_when_idle", LW'(zero_viol), LW'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
